// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional perf counters in fetch_queue are enabled by FETCH_QUEUE_PERF_EN.
package fetch_queue_pkg;

  localparam int FETCH_WIDTH  = 4;
  localparam int DECODE_WIDTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_npc;
  } fq_entry_t;

  // PC of slot `slot` inside the 16-byte block whose upper bits are `block`.
  function automatic logic [31:0] slot_pc(input logic [27:0] block, input logic [1:0] slot);
    return {block, slot, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-group input and decode-lane output bundle of the fetch queue.
// master = fetch/decode side, slave = the queue.
interface fetch_queue_if;

  logic                                              fg_valid;
  logic [31:0]                                       fg_pc;
  logic [fetch_queue_pkg::FETCH_WIDTH-1:0][31:0]     fg_inst;
  logic [fetch_queue_pkg::FETCH_WIDTH-1:0]           fg_killed;
  logic [fetch_queue_pkg::FETCH_WIDTH-1:0]           fg_pred_res;
  logic [31:0]                                       fg_npc;
  logic                                              fg_ready;

  logic [fetch_queue_pkg::DECODE_WIDTH-1:0]          out_valid;
  logic [fetch_queue_pkg::DECODE_WIDTH-1:0][31:0]    out_pc;
  logic [fetch_queue_pkg::DECODE_WIDTH-1:0][31:0]    out_inst;
  logic [fetch_queue_pkg::DECODE_WIDTH-1:0]          out_pred_taken;
  logic [fetch_queue_pkg::DECODE_WIDTH-1:0][31:0]    out_pred_npc;
  logic                                              out_ready;

  modport master (
    output fg_valid, fg_pc, fg_inst, fg_killed, fg_pred_res, fg_npc, out_ready,
    input  fg_ready, out_valid, out_pc, out_inst, out_pred_taken, out_pred_npc
  );

  modport slave (
    input  fg_valid, fg_pc, fg_inst, fg_killed, fg_pred_res, fg_npc, out_ready,
    output fg_ready, out_valid, out_pc, out_inst, out_pred_taken, out_pred_npc
  );

endinterface

// File: rtl/fq_slot_decode.sv
// Combinational fetch-group slot decode: live mask, live count and the
// first predicted-taken live slot.
module fq_slot_decode
  import fetch_queue_pkg::*;
(
  input  logic [1:0]             start_slot,
  input  logic [FETCH_WIDTH-1:0] killed,
  input  logic [FETCH_WIDTH-1:0] pred_res,
  output logic [FETCH_WIDTH-1:0] live,
  output logic [2:0]             n,
  output logic [1:0]             taken_idx,
  output logic                   taken_valid,
  output logic [FETCH_WIDTH-1:0] pred_taken
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    live        = '0;
    n           = '0;
    taken_idx   = '0;
    taken_valid = 1'b0;
    pred_taken  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      live[i] = (2'(i) >= start_slot) && !killed[i];
      n       = n + 3'(live[i]);
      // Only the lowest-index live taken slot redirects; later slots fall through.
      if (live[i] && pred_res[i] && !taken_valid) begin
        taken_valid   = 1'b1;
        taken_idx     = 2'(i);
        pred_taken[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts live slots of each fetch group into a
// circular buffer and presents up to two in order to decode.
// Define FETCH_QUEUE_PERF_EN to add the perf_full_stall / perf_empty counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]   perf_full_stall,
  output logic [31:0]   perf_empty,
`endif
  fetch_queue_if.slave  fg
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t count;

  fq_entry_t mem_q [DEPTH];

  logic [FETCH_WIDTH-1:0] live;
  logic [FETCH_WIDTH-1:0] pred_taken;
  logic [2:0]             n;
  logic [1:0]             taken_idx;
  logic                   taken_valid;

  logic                   fg_ready;
  logic                   enq;
  logic [1:0]             deq_n;

  logic [FETCH_WIDTH-1:0] wr_en;
  logic [AW-1:0]          wr_idx   [FETCH_WIDTH];
  fq_entry_t              wr_entry [FETCH_WIDTH];
  logic [AW-1:0]          wr_off;

  logic                   unused_bits;

  fq_slot_decode u_slot_decode (
    .start_slot  (fg.fg_pc[3:2]),
    .killed      (fg.fg_killed),
    .pred_res    (fg.fg_pred_res),
    .live        (live),
    .n           (n),
    .taken_idx   (taken_idx),
    .taken_valid (taken_valid),
    .pred_taken  (pred_taken)
  );

  assign unused_bits = ^{fg.fg_pc[1:0], taken_idx, taken_valid};

  // The extra pointer bit makes tail - head the exact occupancy across wrap.
  assign count    = tail_q - head_q;
  assign fg_ready = (count <= ptr_t'(DEPTH - FETCH_WIDTH));
  assign enq      = fg.fg_valid && fg_ready && !flush;

  always_comb begin
    deq_n = '0;
    if (fg.out_ready) begin
      deq_n = (count >= ptr_t'(DECODE_WIDTH)) ? 2'(DECODE_WIDTH) : count[1:0];
    end
  end

  // Compaction: each live slot lands at tail plus the number of live slots before it.
  always_comb begin
    wr_en  = '0;
    wr_off = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i]              = tail_q[AW-1:0] + wr_off;
      wr_entry[i].pc         = slot_pc(fg.fg_pc[31:4], 2'(i));
      wr_entry[i].inst       = fg.fg_inst[i];
      wr_entry[i].pred_taken = pred_taken[i];
      wr_entry[i].pred_npc   = pred_taken[i] ? fg.fg_npc : wr_entry[i].pc + 32'd4;
      wr_en[i]               = enq && live[i];
      wr_off                 = wr_off + AW'(live[i]);
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = head_q + ptr_t'(deq_n);
      if (enq) tail_d = tail_q + ptr_t'(n);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; validity comes only from the pointers.
  always_ff @(posedge clock) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= wr_entry[i];
    end
  end

  // Lane data is zeroed when invalid so uninitialised storage never reaches decode.
  always_comb begin
    fq_entry_t     rd;
    logic [AW-1:0] rd_idx;
    fg.out_valid      = '0;
    fg.out_pc         = '0;
    fg.out_inst       = '0;
    fg.out_pred_taken = '0;
    fg.out_pred_npc   = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      rd_idx = head_q[AW-1:0] + AW'(k);
      rd     = mem_q[rd_idx];
      if (count > ptr_t'(k)) begin
        fg.out_valid[k]      = 1'b1;
        fg.out_pc[k]         = rd.pc;
        fg.out_inst[k]       = rd.inst;
        fg.out_pred_taken[k] = rd.pred_taken;
        fg.out_pred_npc[k]   = rd.pred_npc;
      end
    end
  end

  assign fg.fg_ready = fg_ready;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] full_stall_q, full_stall_d;
  logic [31:0] empty_cnt_q, empty_cnt_d;

  // Saturating counters; flush does not touch them.
  always_comb begin
    full_stall_d = full_stall_q;
    empty_cnt_d  = empty_cnt_q;
    if (fg.fg_valid && !fg_ready && (full_stall_q != '1)) full_stall_d = full_stall_q + 32'd1;
    if ((count == '0) && !flush && (empty_cnt_q != '1))   empty_cnt_d  = empty_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_stall_q <= '0;
      empty_cnt_q  <= '0;
    end else begin
      full_stall_q <= full_stall_d;
      empty_cnt_q  <= empty_cnt_d;
    end
  end

  assign perf_full_stall = full_stall_q;
  assign perf_empty      = empty_cnt_q;
`endif

endmodule
